// File: rtl/apb2axi_rsp_collector.sv
`timescale 1ns/1ps
`default_nettype none
// apb2axi_rsp_collector: AXI R/B beat collector feeding the read buffer and completion FIFO.
// Optional APB2AXI_RLAST_CHECK_EN checks burst length against the issued ARLEN.  Rev 1.0
module apb2axi_rsp_collector #(
  parameter  int TAG_NUM       = 16,
  parameter  int MAX_BEATS_NUM = 16,
  parameter  int AXI_DATA_W    = 32,
  localparam int TAG_W         = $clog2(TAG_NUM),
  localparam int AXI_ID_W      = TAG_W,
  localparam int BEAT_W        = $clog2(MAX_BEATS_NUM),
  localparam int COMPLETION_W  = 1 + TAG_W + 2 + 1 + 8
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    rd_issue_valid,
  input  logic [TAG_W-1:0]        rd_issue_tag,
  input  logic [7:0]              rd_issue_len,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic                    rlast,
  input  logic [AXI_ID_W-1:0]     rid,
  input  logic [AXI_DATA_W-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [AXI_ID_W-1:0]     bid,
  input  logic [1:0]              bresp,
  output logic                    rdbuf_we,
  output logic [TAG_W-1:0]        rdbuf_tag,
  output logic [BEAT_W-1:0]       rdbuf_beat,
  output logic [AXI_DATA_W-1:0]   rdbuf_data,
  output logic                    cpl_valid,
  input  logic                    cpl_ready,
  output logic [COMPLETION_W-1:0] cpl_entry
);

  typedef struct packed {
    logic             is_write;
    logic [TAG_W-1:0] tag;
    logic [1:0]       resp;
    logic             error;
    logic [7:0]       num_beats;
  } completion_entry_t;

  localparam logic [7:0] MAX_BEATS = 8'(MAX_BEATS_NUM);

  logic [7:0] beat_cnt [TAG_NUM];
  logic [1:0] resp_acc [TAG_NUM];
  logic       err_acc  [TAG_NUM];

  completion_entry_t rh_entry, bh_entry;
  logic rh_valid, bh_valid;
  logic prio, pending, sel_b_q, sel_b, grant;
  logic r_hs, b_hs, overflow, len_err, merged_err;
  logic [7:0] cur_cnt;
  logic [1:0] cur_resp, merged_resp;
  logic       cur_err;

  assign r_hs        = rvalid && rready;
  assign b_hs        = bvalid && bready;
  assign cur_cnt     = beat_cnt[rid];
  assign cur_resp    = resp_acc[rid];
  assign cur_err     = err_acc[rid];
  assign overflow    = (cur_cnt >= MAX_BEATS);
  assign merged_resp = (rresp > cur_resp) ? rresp : cur_resp;

`ifdef APB2AXI_RLAST_CHECK_EN
  logic [7:0] exp_len [TAG_NUM];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < TAG_NUM; i++) exp_len[i] <= '0;
    end else if (rd_issue_valid) begin
      exp_len[rd_issue_tag] <= rd_issue_len;
    end
  end

  // Last beat must land on exp_len; a non-last beat landing there means the burst overruns.
  assign len_err = rlast ? (cur_cnt != exp_len[rid]) : (cur_cnt == exp_len[rid]);
`else
  logic unused_issue;
  assign unused_issue = ^{rd_issue_valid, rd_issue_tag, rd_issue_len};
  assign len_err      = 1'b0;
`endif

  assign merged_err = cur_err | rresp[1] | overflow | len_err;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < TAG_NUM; i++) begin
        beat_cnt[i] <= '0;
        resp_acc[i] <= '0;
        err_acc[i]  <= 1'b0;
      end
    end else if (r_hs) begin
      if (rlast) begin
        beat_cnt[rid] <= '0;
        resp_acc[rid] <= '0;
        err_acc[rid]  <= 1'b0;
      end else begin
        beat_cnt[rid] <= cur_cnt + 8'd1;
        resp_acc[rid] <= merged_resp;
        err_acc[rid]  <= merged_err;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdbuf_we   <= 1'b0;
      rdbuf_tag  <= '0;
      rdbuf_beat <= '0;
      rdbuf_data <= '0;
    end else begin
      rdbuf_we <= r_hs && !overflow;
      if (r_hs) begin
        rdbuf_tag  <= rid;
        rdbuf_beat <= cur_cnt[BEAT_W-1:0];
        rdbuf_data <= rdata;
      end
    end
  end

  assign rready    = !rh_valid;
  assign bready    = !bh_valid;
  assign cpl_valid = rh_valid || bh_valid;
  assign grant     = cpl_valid && cpl_ready;

  // A presented but unaccepted entry stays selected so the output is stable under back-pressure.
  always_comb begin
    sel_b = bh_valid;
    if (pending)                   sel_b = sel_b_q;
    else if (rh_valid && bh_valid) sel_b = prio;
  end

  always_comb begin
    cpl_entry = '0;
    if (cpl_valid) cpl_entry = sel_b ? bh_entry : rh_entry;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rh_valid <= 1'b0;
      rh_entry <= '0;
      bh_valid <= 1'b0;
      bh_entry <= '0;
      prio     <= 1'b0;
      pending  <= 1'b0;
      sel_b_q  <= 1'b0;
    end else begin
      if (r_hs && rlast) begin
        rh_valid <= 1'b1;
        rh_entry <= {1'b0, rid, merged_resp, merged_err, cur_cnt + 8'd1};
      end else if (grant && !sel_b) begin
        rh_valid <= 1'b0;
      end
      if (b_hs) begin
        bh_valid <= 1'b1;
        bh_entry <= {1'b1, bid, bresp, bresp[1], 8'd1};
      end else if (grant && sel_b) begin
        bh_valid <= 1'b0;
      end
      if (grant && rh_valid && bh_valid) prio <= ~prio;
      pending <= cpl_valid && !cpl_ready;
      sel_b_q <= sel_b;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb2axi_rsp_collector.sv
`timescale 1ns/1ps
`default_nettype none
// Self-checking bench for apb2axi_rsp_collector: scoreboard against a per-tag reference model.
module tb_apb2axi_rsp_collector;
  localparam int TAG_NUM = 16, MAX_BEATS_NUM = 16, DW = 32, CW = 16;
`ifdef APB2AXI_RLAST_CHECK_EN
  localparam bit LEN_CHK = 1'b1;
`else
  localparam bit LEN_CHK = 1'b0;
`endif

  logic aclk = 1'b0, aresetn = 1'b0;
  logic rd_issue_valid = 0; logic [3:0] rd_issue_tag = 0; logic [7:0] rd_issue_len = 0;
  logic rvalid = 0, rlast = 0; logic [3:0] rid = 0; logic [DW-1:0] rdata = 0; logic [1:0] rresp = 0;
  logic bvalid = 0; logic [3:0] bid = 0; logic [1:0] bresp = 0;
  logic rready, bready, rdbuf_we, cpl_valid;
  logic cpl_ready = 1'b1;
  logic [3:0] rdbuf_tag, rdbuf_beat; logic [DW-1:0] rdbuf_data; logic [CW-1:0] cpl_entry;

  always #5 aclk = ~aclk;

  apb2axi_rsp_collector #(.TAG_NUM(TAG_NUM), .MAX_BEATS_NUM(MAX_BEATS_NUM), .AXI_DATA_W(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .rd_issue_valid(rd_issue_valid), .rd_issue_tag(rd_issue_tag), .rd_issue_len(rd_issue_len),
    .rvalid(rvalid), .rready(rready), .rlast(rlast), .rid(rid), .rdata(rdata), .rresp(rresp),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .rdbuf_we(rdbuf_we), .rdbuf_tag(rdbuf_tag), .rdbuf_beat(rdbuf_beat), .rdbuf_data(rdbuf_data),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_entry(cpl_entry));

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk(input logic w, input logic [3:0] t, input logic [1:0] r,
                                       input logic e, input logic [7:0] n);
    return {w, t, r, e, n};
  endfunction

  // Reference model: per-tag progress of each burst, expected outputs queued per source.
  int         m_cnt [TAG_NUM];
  logic [1:0] m_resp[TAG_NUM];
  bit         m_err [TAG_NUM];
  int         m_exp [TAG_NUM];
  logic [CW-1:0]   rq[$], bq[$];
  logic [DW+7:0]   wq[$];
  bit              grant_log[$];
  logic [CW-1:0]   last_rcpl, prev_entry;
  bit              prev_hold = 0;
  int              wr_count = 0;

  always @(negedge aclk) begin
    int c; logic [1:0] rs; bit e; logic [CW-1:0] got;
    if (!aresetn) begin
      for (int i = 0; i < TAG_NUM; i++) begin m_cnt[i] = 0; m_resp[i] = 0; m_err[i] = 0; m_exp[i] = 0; end
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        check("cpl_hold_valid", cpl_valid, 1);
        check("cpl_hold_entry", cpl_entry, prev_entry);
      end
      prev_hold  = cpl_valid && !cpl_ready;
      prev_entry = cpl_entry;
      if (rdbuf_we) begin
        wr_count++;
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rdbuf_unexpected: got tag %0d beat %0d, required no write", rdbuf_tag, rdbuf_beat);
        end else check("rdbuf", {rdbuf_tag, rdbuf_beat, rdbuf_data}, wq.pop_front());
      end
      if (cpl_valid && cpl_ready) begin
        got = cpl_entry;
        grant_log.push_back(got[CW-1]);
        if (got[CW-1]) begin
          if (bq.size() == 0) begin checks++; errors++; $display("FAIL b_cpl_unexpected: got %0h", got); end
          else check("b_cpl", got, bq.pop_front());
        end else begin
          last_rcpl = got;
          if (rq.size() == 0) begin checks++; errors++; $display("FAIL r_cpl_unexpected: got %0h", got); end
          else check("r_cpl", got, rq.pop_front());
        end
      end
      if (rvalid && rready) begin
        c  = m_cnt[rid];
        rs = (rresp > m_resp[rid]) ? rresp : m_resp[rid];
        e  = m_err[rid] || rresp[1] || (c >= MAX_BEATS_NUM);
        if (LEN_CHK && (rlast ? (c != m_exp[rid]) : (c == m_exp[rid]))) e = 1;
        if (c < MAX_BEATS_NUM) wq.push_back({rid, 4'(c), rdata});
        if (rlast) begin
          rq.push_back(mk(1'b0, rid, rs, e, 8'(c + 1)));
          m_cnt[rid] = 0; m_resp[rid] = 0; m_err[rid] = 0;
        end else begin
          m_cnt[rid] = c + 1; m_resp[rid] = rs; m_err[rid] = e;
        end
      end
      if (bvalid && bready) bq.push_back(mk(1'b1, bid, bresp, bresp[1], 8'd1));
      if (rd_issue_valid) m_exp[rd_issue_tag] = int'(rd_issue_len);
    end
  end

  // All driver tasks start and end at posedge + 1.
  task automatic issue(input int tag, input int len);
    rd_issue_valid = 1; rd_issue_tag = 4'(tag); rd_issue_len = 8'(len);
    @(posedge aclk); #1; rd_issue_valid = 0;
  endtask

  task automatic send_r(input int tag, input logic [1:0] resp, input bit last);
    int n = 0;
    rvalid = 1; rid = 4'(tag); rdata = $urandom; rresp = resp; rlast = last;
    @(negedge aclk);
    while (!rready && n < 200) begin @(negedge aclk); n++; end
    check("r_accept_timeout", n < 200, 1);
    @(posedge aclk); #1; rvalid = 0; rlast = 0;
  endtask

  task automatic send_b(input int tag, input logic [1:0] resp);
    int n = 0;
    bvalid = 1; bid = 4'(tag); bresp = resp;
    @(negedge aclk);
    while (!bready && n < 200) begin @(negedge aclk); n++; end
    check("b_accept_timeout", n < 200, 1);
    @(posedge aclk); #1; bvalid = 0;
  endtask

  task automatic burst(input int tag, input int len, input int nb, input logic [1:0] last_resp);
    issue(tag, len);
    for (int i = 0; i < nb; i++) send_r(tag, (i == nb - 1) ? last_resp : 2'b00, i == nb - 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic both_last(input int rtag, input int btag);
    issue(rtag, 0);
    rvalid = 1; rid = 4'(rtag); rdata = $urandom; rresp = 0; rlast = 1;
    bvalid = 1; bid = 4'(btag); bresp = 0;
    @(posedge aclk); #1; rvalid = 0; rlast = 0; bvalid = 0;
    @(negedge aclk);
    check("both_rready_low", rready, 0);
    check("both_bready_low", bready, 0);
    check("both_cpl_valid", cpl_valid, 1);
    grant_log.delete();
    @(posedge aclk); #1; cpl_ready = 1;
    idle(2); cpl_ready = 0;
  endtask

  task automatic r_rand();
    int tag, len, nb;
    repeat (40) begin
      tag = $urandom_range(0, 15);
      len = $urandom_range(0, 18);
      nb  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 20) : len + 1;
      issue(tag, len);
      for (int i = 0; i < nb; i++) send_r(tag, 2'($urandom_range(0, 3)), i == nb - 1);
      idle($urandom_range(0, 2));
    end
  endtask

  task automatic b_rand();
    repeat (40) begin
      idle($urandom_range(0, 4));
      send_b($urandom_range(0, 15), 2'($urandom_range(0, 3)));
    end
  endtask

  bit rnd_done;
  int wr_before;

  initial begin
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst_rready", rready, 1);
    check("rst_bready", bready, 1);
    check("rst_rdbuf_we", rdbuf_we, 0);
    check("rst_rdbuf_fields", {rdbuf_tag, rdbuf_beat, rdbuf_data}, 0);
    check("rst_cpl_valid", cpl_valid, 0);
    check("rst_cpl_entry", cpl_entry, 0);
    @(posedge aclk); #1; aresetn = 1;
    idle(2);

    burst(3, 3, 4, 2'b00); idle(3);
    check("t1_cpl", last_rcpl, mk(1'b0, 4'd3, 2'b00, 1'b0, 8'd4));

    send_b(5, 2'b10);
    @(negedge aclk);
    check("t2_b_valid", cpl_valid, 1);
    check("t2_b_entry", cpl_entry, mk(1'b1, 4'd5, 2'b10, 1'b1, 8'd1));
    idle(2);

    burst(2, 1, 2, 2'b11); idle(3);
    check("t3_cpl", last_rcpl, mk(1'b0, 4'd2, 2'b11, 1'b1, 8'd2));

    cpl_ready = 0;
    both_last(1, 7);
    check("t4_first_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("t4_first_is_r", grant_log[0], 0);
      check("t4_second_is_b", grant_log[1], 1);
    end
    both_last(1, 7);
    check("t4_repeat_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("t4_repeat_is_b", grant_log[0], 1);
      check("t4_repeat_then_r", grant_log[1], 0);
    end
    cpl_ready = 1; idle(3);

    burst(6, 3, 2, 2'b00); idle(3);
    check("t5_cpl", last_rcpl, mk(1'b0, 4'd6, 2'b00, LEN_CHK, 8'd2));

    wr_before = wr_count;
    burst(0, 16, 17, 2'b00); idle(3);
    check("t6_writes", wr_count - wr_before, 16);
    check("t6_cpl", last_rcpl, mk(1'b0, 4'd0, 2'b00, 1'b1, 8'd17));

    issue(4, 5);
    for (int i = 0; i < 3; i++) send_r(4, 2'b01, 1'b0);
    idle(3);
    aresetn = 0;
    @(negedge aclk);
    check("t7_rst_cpl_valid", cpl_valid, 0);
    check("t7_rst_rready", rready, 1);
    idle(2); aresetn = 1; idle(1);
    burst(4, 1, 2, 2'b00); idle(3);
    check("t7_cpl_after_rst", last_rcpl, mk(1'b0, 4'd4, 2'b00, 1'b0, 8'd2));

    rnd_done = 0;
    fork
      begin
        fork r_rand(); b_rand(); join
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin cpl_ready = ($urandom_range(0, 3) != 0); @(posedge aclk); #1; end
      end
    join
    cpl_ready = 1; idle(10);

    check("end_rq_empty", rq.size(), 0);
    check("end_bq_empty", bq.size(), 0);
    check("end_wq_empty", wq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/apb2axi_rsp_collector.md
# apb2axi_rsp_collector

AXI-side response collector of the APB2AXI converter. Accepts read-data (R) and write-response (B) beats from the AXI fabric, tracks per-tag beat counts and accumulated response, writes read beats into the read-data buffer, and emits one `completion_entry_t` per finished transaction toward the completion FIFO read by the APB gateway. It is the receive-side counterpart of the request issuer that drains `directory_entry_t` onto AR/AW.

## Interface
- `TAG_NUM`, 16: tracked tags; AXI ID equals tag (`AXI_ID_W == TAG_W`).
- `MAX_BEATS_NUM`, 16: read-buffer slots per tag.
- `aclk`  in  1  clock.
- `aresetn`  in  1  asynchronous active-low reset.
- `rd_issue_valid`  in  1  read AR issued this cycle; loads the expected length.
- `rd_issue_tag`  in  TAG_W  tag of the issued read.
- `rd_issue_len`  in  8  AXI ARLEN of the issued read.
- `rvalid`, `rready`, `rlast`  in/out/in  1 each  AXI R handshake.
- `rid`  in  AXI_ID_W;  `rdata`  in  AXI_DATA_W;  `rresp`  in  2.
- `bvalid`, `bready`  in/out  1 each;  `bid`  in  AXI_ID_W;  `bresp`  in  2.
- `rdbuf_we`  out  1  read-buffer write strobe.
- `rdbuf_tag`  out  TAG_W;  `rdbuf_beat`  out  $clog2(MAX_BEATS_NUM);  `rdbuf_data`  out  AXI_DATA_W.
- `cpl_valid`  out  1  completion available.
- `cpl_ready`  in  1  completion FIFO accepts.
- `cpl_entry`  out  COMPLETION_W  packed `completion_entry_t`.

## Operation
- Per tag: `beat_cnt[tag]` (8b), `resp_acc[tag]` (2b), `err_acc[tag]` (1b), `exp_len[tag]` (8b).
- R handshake (`rvalid && rready`): `rdbuf_*` registered with `beat = beat_cnt[rid]` low bits, `beat_cnt++`, `resp_acc = max(resp_acc, rresp)` (numeric max: DECERR>SLVERR>EXOKAY>OKAY), `err_acc |= (rresp[1])`.
- Beat with `beat_cnt >= MAX_BEATS_NUM`: `rdbuf_we` suppressed, `err_acc` set.
- R handshake with `rlast`: R hold register loaded with `{is_write=0, tag=rid, resp=merged, error=merged, num_beats=beat_cnt+1}`; tag state cleared same cycle.
- B handshake: B hold register loaded with `{is_write=1, tag=bid, resp=bresp, error=bresp[1], num_beats=1}`.
- `rready = !r_hold_valid`; `bready = !b_hold_valid` (registered-only dependence).
- Output arbiter: one hold valid -> present it; both valid -> `prio` bit selects (reset = R), `prio` toggles on every grant made while both are valid.
- `cpl_valid && cpl_ready` clears the granted hold register.
- `rd_issue_valid` overwrites `exp_len[rd_issue_tag]`; same-tag R beat in the same cycle uses the old tag counters (issue does not clear them).

## Timing
- Reset values: `rready=1`, `bready=1`, `rdbuf_we=0`, `rdbuf_tag/beat/data=0`, `cpl_valid=0`, `cpl_entry=0`, all counters/accumulators 0, `prio`=R.
- `rdbuf_*`: 1 cycle after R handshake.
- Completion: `cpl_valid` 1 cycle after last-R or B handshake; held stable until `cpl_ready`.
- Hold clear and reload in same cycle allowed: `rready` stays low that cycle (registered), new beat accepted next cycle; max sustained rate 1 completion per source every 2 cycles under back-pressure-free sink, R non-last beats 1/cycle.
- Simultaneous last-R and B: both accepted, both hold registers fill, arbiter drains in `prio` order.
- Reset mid-burst: partial tag state discarded; no completion emitted.

## Configuration
- `APB2AXI_RLAST_CHECK_EN` defined: on last-R, `error` additionally set if `beat_cnt+1 != exp_len+1`; a non-last beat reaching `beat_cnt == exp_len` also sets `err_acc`.
- Undefined: `exp_len` storage and `rd_issue_*` ignored; error only from response codes and buffer overflow.

## Test plan
- Issue tag 3 len 3; 4 R beats OKAY, last on 4th -> rdbuf beats 0..3 tag 3, one completion `{0,3,OKAY,0,4}`.
- B on id 5 SLVERR with `cpl_ready=1` -> `{1,5,2'b10,1,1}` one cycle later.
- Tag 2 len 1; beats OKAY, DECERR(last) -> completion resp=3, error=1, num_beats=2.
- `cpl_ready=0`, last-R tag 1 and B tag 7 same cycle -> both held, `rready=bready=0`; release -> R first, then B; repeat -> B first.
- With `APB2AXI_RLAST_CHECK_EN`: len 3, `rlast` on beat 2 -> error=1, num_beats=2; without macro -> error=0.
- 17 beats tag 0 -> 16 `rdbuf_we`, completion num_beats=17, error=1; `aresetn` low mid-burst -> `cpl_valid=0`, next burst starts at beat 0.
